alu_mc: RTL and testbench

- Parametrised multi-cycle ALU; successor to the single-cycle 64-bit datapath ALU.
- Adds a valid/ready handshake on input and output.
- ADD/SUB/MUL/shift/logic ops complete in 1 cycle; DIV runs on an iterative restoring divider (1 quotient bit per cycle).
- Adds logic ops, arithmetic shift, and a divide-by-zero flag. Sits between decode/issue and writeback in the execute stage.

---
 rtl/alu_mc_if.sv | 35 +++
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_alu_mc.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle for the multi-cycle ALU.
//
// Handshake rules, both directions:
//   A transfer happens at a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its payload stable until that edge.
//   ready may be asserted with or without valid; it never depends on valid.
//   Input side:  in_valid/in_ready carry ctl, a and b.
//   Output side: out_valid/out_ready carry out, zero and div0.
interface alu_mc_if #(
  parameter int WIDTH = 64,
  parameter int CTL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [CTL_W-1:0] ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             div0;
  logic             busy;
  logic             dbg_state;  // 0 = IDLE, 1 = DIV

  modport slave (
    input  in_valid, ctl, a, b, out_ready,
    output in_ready, out_valid, out, zero, div0, busy, dbg_state
  );

  modport master (
    output in_valid, ctl, a, b, out_ready,
    input  in_ready, out_valid, out, zero, div0, busy, dbg_state
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU with valid/ready on both sides.
// Single-cycle ops: ADD SUB MUL SHL SHR NOT AND OR XOR SAR, plus DIV by zero.
// DIV with a non-zero divisor runs a restoring divider, one quotient bit per cycle.
// Optional macro ALU_MC_REM_EN enables opcode 12 = REM on the same divider.
module alu_mc #(
  parameter int WIDTH = 64,
  parameter int CTL_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_mc_if.slave     bus
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [CTL_W-1:0] OP_SUB = CTL_W'(2);
  localparam logic [CTL_W-1:0] OP_MUL = CTL_W'(3);
  localparam logic [CTL_W-1:0] OP_SHL = CTL_W'(4);
  localparam logic [CTL_W-1:0] OP_SHR = CTL_W'(5);
  localparam logic [CTL_W-1:0] OP_DIV = CTL_W'(6);
  localparam logic [CTL_W-1:0] OP_NOT = CTL_W'(7);
  localparam logic [CTL_W-1:0] OP_AND = CTL_W'(8);
  localparam logic [CTL_W-1:0] OP_OR  = CTL_W'(9);
  localparam logic [CTL_W-1:0] OP_XOR = CTL_W'(10);
  localparam logic [CTL_W-1:0] OP_SAR = CTL_W'(11);
`ifdef ALU_MC_REM_EN
  localparam logic [CTL_W-1:0] OP_REM = CTL_W'(12);
`endif

  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_div0;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
`ifdef ALU_MC_REM_EN
  logic             r_is_rem;
`endif

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_divop;
  logic             w_div_start;
  logic             w_sh_big;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_res_div0;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_done_res;
  logic             w_last;

  assign w_in_ready  = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_div_start = w_is_divop && (bus.b != '0);
  // Any set bit at or above SH_W means b >= WIDTH (WIDTH is a power of 2).
  assign w_sh_big    = |bus.b[WIDTH-1:SH_W];
  assign w_sh        = bus.b[SH_W-1:0];
  assign w_last      = (r_cnt == CNT_W'(1));

  // Opcodes that go to the divider when the divisor is non-zero.
  always_comb begin
    w_is_divop = (bus.ctl == OP_DIV);
`ifdef ALU_MC_REM_EN
    if (bus.ctl == OP_REM) w_is_divop = 1'b1;
`endif
  end

  // Single-cycle result decode; unknown opcodes fall back to ADD.
  always_comb begin
    w_res      = bus.a + bus.b;
    w_res_div0 = 1'b0;
    case (bus.ctl)
      OP_SUB: w_res = bus.a - bus.b;
      OP_MUL: w_res = bus.a * bus.b;
      OP_SHL: w_res = w_sh_big ? '0 : (bus.a << w_sh);
      OP_SHR: w_res = w_sh_big ? '0 : (bus.a >> w_sh);
      OP_DIV: begin
        w_res      = '1;
        w_res_div0 = 1'b1;
      end
      OP_NOT: w_res = ~bus.a;
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_XOR: w_res = bus.a ^ bus.b;
      OP_SAR: w_res = w_sh_big ? {WIDTH{bus.a[WIDTH-1]}}
                               : WIDTH'($signed(bus.a) >>> w_sh);
`ifdef ALU_MC_REM_EN
      OP_REM: begin
        w_res      = bus.a;
        w_res_div0 = 1'b1;
      end
`endif
      default: w_res = bus.a + bus.b;
    endcase
  end

  // One restoring-division step. The shifted remainder needs WIDTH+1 bits;
  // when the trial subtract succeeds the difference always fits in WIDTH.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    w_trial   = w_rem_sh[WIDTH-1:0] - r_dvs;
    w_rem_nxt = w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
`ifdef ALU_MC_REM_EN
    w_done_res = r_is_rem ? w_rem_nxt : w_quo_nxt;
`else
    w_done_res = w_quo_nxt;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: IDLE -> DIV on a divider start, DIV -> IDLE on the last step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_div_start) w_state_nxt = S_DIV;
      S_DIV:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers and divider datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_zero      <= 1'b1;
      r_div0      <= 1'b0;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
`ifdef ALU_MC_REM_EN
      r_is_rem    <= 1'b0;
`endif
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        if (w_div_start) begin
          r_rem    <= '0;
          r_quo    <= bus.a;
          r_dvs    <= bus.b;
          r_cnt    <= CNT_W'(WIDTH);
`ifdef ALU_MC_REM_EN
          r_is_rem <= (bus.ctl == OP_REM);
`endif
        end else begin
          r_out       <= w_res;
          r_zero      <= (w_res == '0);
          r_div0      <= w_res_div0;
          r_out_valid <= 1'b1;
        end
      end else if (r_state == S_DIV) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_out       <= w_done_res;
          r_zero      <= (w_done_res == '0);
          r_div0      <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.zero      = r_zero;
  assign bus.div0      = r_div0;
  assign bus.busy      = (r_state == S_DIV);
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven single-cycle vectors plus hand sequences for the
// divider, backpressure and reset abort. Optional macro ALU_MC_REM_EN adds REM.
module tb_alu_mc;
  localparam int W  = 64;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W), .CTL_W(CW)) bus ();
  alu_mc #(.WIDTH(W), .CTL_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_d0_q[$];
  logic [W-1:0] mon_e;
  logic         mon_d;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Every result transfer (out_valid && out_ready) pops and compares.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got 0x%0h want none", bus.out);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = exp_d0_q.pop_front();
        chk("out", bus.out, mon_e);
        chk("zero", W'(bus.zero), W'(mon_e == '0));
        chk("div0", W'(bus.div0), W'(mon_d));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] e, input logic d, input bit push, output int waited);
    bus.ctl = c;
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    waited = 0;
    #1;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      tick;
      waited++;
      #1;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %b want 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(e);
      exp_d0_q.push_back(d);
    end
    tick;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick;
      n++;
    end
    chk("drain_left", W'(exp_q.size()), '0);
  endtask

  // Run a divider op and measure busy cycles and edges to out_valid.
  task automatic div_seq(input logic [CW-1:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] e, input string name);
    int w;
    int edges = 0;
    int busy_cnt = 0;
    send(c, av, bv, e, 1'b0, 1'b1, w);
    while (bus.out_valid !== 1'b1 && edges < 200) begin
      if (bus.busy === 1'b1 && bus.in_ready === 1'b0 && bus.dbg_state === 1'b1) busy_cnt++;
      tick;
      edges++;
    end
    chk({name, "_edges_after_accept"}, W'(edges), W'(W));
    chk({name, "_busy_cycles"}, W'(busy_cnt), W'(W));
    chk({name, "_busy_end"}, W'(bus.busy), '0);
    drain;
  endtask

  typedef struct {
    logic [CW-1:0] ctl;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  exp;
    logic          d0;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int w;
    bit rose;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Single-cycle vectors; expectations written out by hand.
    vecs.push_back('{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0, 1'b0});
    vecs.push_back('{4'd11, 64'h8000_0000_0000_0000, 64'd70, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{4'd4,  64'd1, 64'd64, 64'd0, 1'b0});
    vecs.push_back('{4'd1,  64'd2, 64'd3, 64'd5, 1'b0});
    vecs.push_back('{4'd2,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{4'd3,  64'd3, 64'd4, 64'd12, 1'b0});
    vecs.push_back('{4'd10, 64'hF0, 64'hFF, 64'h0F, 1'b0});
    vecs.push_back('{4'd3,  64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 1'b0});
    vecs.push_back('{4'd5,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0});
    vecs.push_back('{4'd5,  64'hFFFF, 64'd64, 64'd0, 1'b0});
    vecs.push_back('{4'd4,  64'h1234, 64'd4, 64'h12340, 1'b0});
    vecs.push_back('{4'd4,  64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0});
    vecs.push_back('{4'd7,  64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{4'd8,  64'hF0F0, 64'hFF00, 64'hF000, 1'b0});
    vecs.push_back('{4'd9,  64'hF0, 64'h0F, 64'hFF, 1'b0});
    vecs.push_back('{4'd11, 64'hF000_0000_0000_0000, 64'd4, 64'hFF00_0000_0000_0000, 1'b0});
    vecs.push_back('{4'd11, 64'h7000_0000_0000_0000, 64'd70, 64'd0, 1'b0});
    vecs.push_back('{4'd6,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{4'd0,  64'd7, 64'd8, 64'd15, 1'b0});
    vecs.push_back('{4'd13, 64'd7, 64'd8, 64'd15, 1'b0});
    vecs.push_back('{4'd15, 64'd1, 64'd1, 64'd2, 1'b0});
`ifdef ALU_MC_REM_EN
    vecs.push_back('{4'd12, 64'd5, 64'd0, 64'd5, 1'b1});
`else
    vecs.push_back('{4'd12, 64'd5, 64'd3, 64'd8, 1'b0});
`endif

    // Reset.
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ctl = '0;
    bus.a = '0;
    bus.b = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_out", bus.out, '0);
    chk("rst_zero", W'(bus.zero), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_div0", W'(bus.div0), '0);

    // Stream the table at one op per cycle.
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].d0, 1'b1, w);
      chk("stream_wait", W'(w), '0);
    end
    drain;

    // Divider latency and values.
    div_seq(4'd6, 64'd100, 64'd7, 64'd14, "div_100_7");
    div_seq(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, "div_big");
    div_seq(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, "div_near");
    div_seq(4'd6, 64'd3, 64'd10, 64'd0, "div_small");
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom(), $urandom()};
      rb = (i == 0) ? W'($urandom_range(1, 1000)) : {32'($urandom_range(0, 255)), $urandom()} + 64'd1;
      div_seq(4'd6, ra, rb, ra / rb, "div_rand");
    end
`ifdef ALU_MC_REM_EN
    div_seq(4'd12, 64'd100, 64'd7, 64'd2, "rem_100_7");
`endif

    // DIV accepted on the same edge the previous result is consumed.
    send(4'd1, 64'd1, 64'd2, 64'd3, 1'b0, 1'b1, w);
    send(4'd6, 64'd50, 64'd5, 64'd10, 1'b0, 1'b1, w);
    chk("div_after_consume_valid", W'(bus.out_valid), '0);
    drain;

    // Backpressure: result held, new request stalled, released on one edge.
    bus.out_ready = 1'b0;
    send(4'd1, 64'd3, 64'd4, 64'd7, 1'b0, 1'b1, w);
    bus.ctl = 4'd1;
    bus.a = 64'd10;
    bus.b = 64'd20;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", W'(bus.in_ready), '0);
      chk("hold_out", bus.out, 64'd7);
      chk("hold_valid", W'(bus.out_valid), W'(1));
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", W'(bus.in_ready), W'(1));
    exp_q.push_back(64'd30);
    exp_d0_q.push_back(1'b0);
    tick;
    bus.in_valid = 1'b0;
    chk("release_out", bus.out, 64'd30);
    chk("release_valid", W'(bus.out_valid), W'(1));
    drain;

    // Reset in the middle of a division.
    send(4'd6, 64'd1000, 64'd3, '0, 1'b0, 1'b0, w);
    for (int i = 0; i < 29; i++) tick;
    chk("abort_pre_busy", W'(bus.busy), W'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_state", W'(bus.dbg_state), '0);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_valid", W'(bus.out_valid), '0);
    rose = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.out_valid !== 1'b0) rose = 1'b1;
      tick;
    end
    chk("abort_no_result", W'(rose), '0);
    send(4'd1, 64'd1, 64'd1, 64'd2, 1'b0, 1'b1, w);
    drain;

    chk("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
